aes_dec_ctrl: RTL and testbench

Sequencing FSM for the iterative AES-128 decryption core that sits behind the Avalon-MM AES register interface. It takes the start bit from the register file and steps a shared datapath through key expansion, the initial AddRoundKey, nine full inverse rounds and the final round. It drives the datapath's operation select, round-key index, state-register load and output latch, then raises the done bit. It holds done until software clears start.

---
 rtl/aes_dec_ctrl_if.sv | 27 ++
 rtl/aes_dec_ctrl.sv | 168 ++++++++++++++++
 tb/tb_aes_dec_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_ctrl_if.sv
// Control bundle between the AES-128 decryption sequencer and the register file / datapath.
// master: the sequencer (samples AES_START, drives every datapath control and status output).
// slave:  the register file / datapath side (drives AES_START, observes the controls).
interface aes_dec_ctrl_if;
    logic       AES_START;   // start request from the register file, level
    logic       AES_DONE;    // decryption complete, held until AES_START is low
    logic       busy;        // a run is between IDLE and DONE
    logic       keyexp_en;   // key-expansion unit enable
    logic       state_ld;    // state register captures the selected source
    logic       state_init;  // state register source is the encrypted message
    logic [1:0] op_sel;      // 0 ARK, 1 InvShiftRows, 2 InvSubBytes, 3 InvMixColumns
    logic [3:0] round_idx;   // round-key index 0..10
    logic [1:0] imc_col;     // column handled by the shared InvMixColumns unit
    logic       msg_dec_ld;  // latch state register into the decrypted-message output

    modport master (
        input  AES_START,
        output AES_DONE, busy, keyexp_en, state_ld, state_init,
               op_sel, round_idx, imc_col, msg_dec_ld
    );

    modport slave (
        output AES_START,
        input  AES_DONE, busy, keyexp_en, state_ld, state_init,
               op_sel, round_idx, imc_col, msg_dec_ld
    );
endinterface

// File: rtl/aes_dec_ctrl.sv
// Sequencer for the iterative AES-128 decryption datapath: key expansion, ARK0, 9 full inverse rounds, final round.
// Latency: AES_DONE rises KEYEXP_CYCLES + 9*(6+SBOX_LAT) + 5 + SBOX_LAT edges after AES_START is sampled in IDLE.
// Backpressure: none inside a run; AES_DONE is held until AES_START drops, only then can a new run start.
//
// Ports: CLK, RESET (synchronous, active-high) plus the aes_dec_ctrl_if master modport. All outputs are
// flops loaded from the next-state decode, so there is no combinational path from AES_START to any output.
module aes_dec_ctrl #(
    parameter int KEYEXP_CYCLES = 10,  // cycles the key-expansion unit needs (>= 1)
    parameter int SBOX_LAT      = 1    // InvSubBytes latency incl. synchronous S-box ROM (>= 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    aes_dec_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_INIT,
        ST_ARK0,
        ST_ISR,
        ST_ISB,
        ST_ARK,
        ST_IMC,
        ST_STORE,
        ST_DONE
    } state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] KEYEXP_LAST = CNT_W'(KEYEXP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SBOX_LAST   = CNT_W'(SBOX_LAT - 1);
    localparam logic [CNT_W-1:0] IMC_LAST    = CNT_W'(3);

    localparam logic [1:0] OP_ARK = 2'd0;
    localparam logic [1:0] OP_ISR = 2'd1;
    localparam logic [1:0] OP_ISB = 2'd2;
    localparam logic [1:0] OP_IMC = 2'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;       // dwell counter for KEYEXP / ISB / IMC, 0 on every state entry
    logic [3:0]       rnd_q, rnd_d;       // round counter, doubles as the round-key index

    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       keyexp_en_q, keyexp_en_d;
    logic       state_ld_q, state_ld_d;
    logic       state_init_q, state_init_d;
    logic [1:0] op_sel_q, op_sel_d;
    logic [1:0] imc_col_q, imc_col_d;
    logic       msg_dec_ld_q, msg_dec_ld_d;

    // Next state, dwell counter and round counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rnd_d   = rnd_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.AES_START) state_d = ST_KEYEXP;
            end
            ST_KEYEXP: begin
                if (cnt_q == KEYEXP_LAST) state_d = ST_INIT;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            ST_INIT:  state_d = ST_ARK0;
            ST_ARK0:  state_d = ST_ISR;
            ST_ISR:   state_d = ST_ISB;
            ST_ISB: begin
                if (cnt_q == SBOX_LAST) state_d = ST_ARK;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            ST_ARK: begin
                // rnd reaches 0 only in the final round, which has no InvMixColumns
                state_d = (rnd_q != 4'd0) ? ST_IMC : ST_STORE;
            end
            ST_IMC: begin
                if (cnt_q == IMC_LAST) state_d = ST_ISR;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            ST_STORE: state_d = ST_DONE;
            ST_DONE: begin
                if (!bus.AES_START) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase

        // Key 10 is used by ARK0; each new round steps the key index down before its ARK.
        if (state_d == ST_INIT && state_q != ST_INIT) rnd_d = 4'd10;
        if (state_d == ST_ISR  && state_q != ST_ISR)  rnd_d = rnd_q - 4'd1;
    end

    // Output decode from the next state so that every output comes straight from a flop.
    always_comb begin
        done_d       = (state_d == ST_DONE);
        busy_d       = !(state_d inside {ST_IDLE, ST_DONE});
        keyexp_en_d  = (state_d == ST_KEYEXP);
        state_init_d = (state_d == ST_INIT);
        msg_dec_ld_d = (state_d == ST_STORE);
        state_ld_d   = 1'b0;
        op_sel_d     = OP_ARK;
        imc_col_d    = 2'd0;

        unique case (state_d)
            ST_INIT: state_ld_d = 1'b1;
            ST_ARK0, ST_ARK: begin
                state_ld_d = 1'b1;
                op_sel_d   = OP_ARK;
            end
            ST_ISR: begin
                state_ld_d = 1'b1;
                op_sel_d   = OP_ISR;
            end
            ST_ISB: begin
                // the S-box result is only valid in the last cycle of its latency
                state_ld_d = (cnt_d == SBOX_LAST);
                op_sel_d   = OP_ISB;
            end
            ST_IMC: begin
                state_ld_d = 1'b1;
                op_sel_d   = OP_IMC;
                imc_col_d  = cnt_d[1:0];
            end
            default: begin
                state_ld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rnd_q        <= 4'd0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            keyexp_en_q  <= 1'b0;
            state_ld_q   <= 1'b0;
            state_init_q <= 1'b0;
            op_sel_q     <= 2'd0;
            imc_col_q    <= 2'd0;
            msg_dec_ld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rnd_q        <= rnd_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            keyexp_en_q  <= keyexp_en_d;
            state_ld_q   <= state_ld_d;
            state_init_q <= state_init_d;
            op_sel_q     <= op_sel_d;
            imc_col_q    <= imc_col_d;
            msg_dec_ld_q <= msg_dec_ld_d;
        end
    end

    assign bus.AES_DONE   = done_q;
    assign bus.busy       = busy_q;
    assign bus.keyexp_en  = keyexp_en_q;
    assign bus.state_ld   = state_ld_q;
    assign bus.state_init = state_init_q;
    assign bus.op_sel     = op_sel_q;
    assign bus.round_idx  = rnd_q;
    assign bus.imc_col    = imc_col_q;
    assign bus.msg_dec_ld = msg_dec_ld_q;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Bench for aes_dec_ctrl: two instances (default parameters, and KEYEXP_CYCLES=4 / SBOX_LAT=3).
// Expected per-cycle output traces are generated from the round schedule as a list of cycles.
module tb_aes_dec_ctrl;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    aes_dec_ctrl_if if0 ();
    aes_dec_ctrl_if if1 ();

    aes_dec_ctrl dut0 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (if0.master)
    );

    aes_dec_ctrl #(.KEYEXP_CYCLES(4), .SBOX_LAT(3)) dut1 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (if1.master)
    );

    typedef struct packed {
        logic       done;
        logic       busy;
        logic       keyexp_en;
        logic       state_ld;
        logic       state_init;
        logic [1:0] op_sel;
        logic [3:0] round_idx;
        logic [1:0] imc_col;
        logic       msg_dec_ld;
    } obs_t;

    int   n_chk = 0;
    int   n_err = 0;
    obs_t exp_q[$];

    function automatic obs_t mk(input bit b, input bit kx, input bit ld, input bit ini,
                                input int op, input int idx, input int col, input bit msg, input bit dn);
        obs_t o;
        o.done       = dn;
        o.busy       = b;
        o.keyexp_en  = kx;
        o.state_ld   = ld;
        o.state_init = ini;
        o.op_sel     = 2'(op);
        o.round_idx  = 4'(idx);
        o.imc_col    = 2'(col);
        o.msg_dec_ld = msg;
        return o;
    endfunction

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        if (sel == 1) begin
            o.done = if1.AES_DONE;   o.busy = if1.busy;           o.keyexp_en = if1.keyexp_en;
            o.state_ld = if1.state_ld; o.state_init = if1.state_init; o.op_sel = if1.op_sel;
            o.round_idx = if1.round_idx; o.imc_col = if1.imc_col;   o.msg_dec_ld = if1.msg_dec_ld;
        end else begin
            o.done = if0.AES_DONE;   o.busy = if0.busy;           o.keyexp_en = if0.keyexp_en;
            o.state_ld = if0.state_ld; o.state_init = if0.state_init; o.op_sel = if0.op_sel;
            o.round_idx = if0.round_idx; o.imc_col = if0.imc_col;   o.msg_dec_ld = if0.msg_dec_ld;
        end
        return o;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) if1.AES_START = v;
        else          if0.AES_START = v;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_obs(input string tag, input obs_t o, input obs_t e);
        n_chk++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        n_chk++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Cycle list of one run, first KEYEXP cycle through the first DONE cycle.
    task automatic build_exp(input int k, input int s);
        exp_q.delete();
        repeat (k) exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 1, 1, 0, 10, 0, 0, 0));                 // INIT
        exp_q.push_back(mk(1, 0, 1, 0, 0, 10, 0, 0, 0));                 // ARK with key 10
        for (int r = 9; r >= 0; r--) begin
            exp_q.push_back(mk(1, 0, 1, 0, 1, r, 0, 0, 0));              // InvShiftRows
            for (int c = 0; c < s; c++)
                exp_q.push_back(mk(1, 0, (c == s - 1), 0, 2, r, 0, 0, 0)); // InvSubBytes
            exp_q.push_back(mk(1, 0, 1, 0, 0, r, 0, 0, 0));              // AddRoundKey
            if (r != 0)
                for (int c = 0; c < 4; c++)
                    exp_q.push_back(mk(1, 0, 1, 0, 3, r, c, 0, 0));      // InvMixColumns
        end
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));                  // STORE
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));                  // DONE
    endtask

    // One run on instance sel. hold = extra DONE cycles with start still high (0 = start already low).
    // glitch randomises start during the run. reset_at >= 0 fires RESET at that trace index instead of finishing.
    task automatic do_run(input int sel, input int k, input int s, input int hold,
                          input bit glitch, input int reset_at);
        int   l, n_ld, n_msg, first_done;
        int   idx_seq[$];
        obs_t o;
        string nm;
        nm = (sel == 1) ? "cfg1" : "cfg0";
        l = k + 9 * (6 + s) + 5 + s;
        n_ld = 0; n_msg = 0; first_done = -1;
        build_exp(k, s);
        set_start(sel, 1'b1);
        step();                                   // edge e0
        for (int i = 0; i <= l; i++) begin
            o = get_obs(sel);
            chk_obs($sformatf("%s trace[%0d]", nm, i), o, exp_q[i]);
            if (o.state_ld) n_ld++;
            if (o.msg_dec_ld) n_msg++;
            if (o.done && first_done < 0) first_done = i;
            if (o.state_ld && !o.state_init && o.op_sel == 2'd0) idx_seq.push_back(int'(o.round_idx));
            if (i == reset_at) begin
                set_start(sel, 1'b0);
                RESET = 1'b1;
                step();
                RESET = 1'b0;
                chk_obs({nm, " after_reset"}, get_obs(sel), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
                step();
                chk_obs({nm, " idle_after_reset"}, get_obs(sel), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
                return;
            end
            if (i < l) begin
                if (i == l - 1 || !glitch) set_start(sel, (hold > 0) ? 1'b1 : (i == l - 1 ? 1'b0 : 1'b0));
                else                       set_start(sel, 1'($urandom_range(0, 1)));
                if (i < l - 1 && !glitch && hold > 0) set_start(sel, 1'b1);
                step();
            end
        end
        chk_int({nm, " done_latency"}, first_done, l);
        chk_int({nm, " state_ld_count"}, n_ld, 68);
        chk_int({nm, " msg_dec_ld_count"}, n_msg, 1);
        chk_int({nm, " ark_load_count"}, idx_seq.size(), 11);
        for (int j = 0; j < idx_seq.size() && j < 11; j++)
            chk_int($sformatf("%s ark_round_idx[%0d]", nm, j), idx_seq[j], 10 - j);
        for (int j = 0; j < hold; j++) begin
            step();
            o = get_obs(sel);
            chk_obs($sformatf("%s done_held[%0d]", nm, j), o, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        set_start(sel, 1'b0);
        step();
        chk_obs({nm, " done_drop"}, get_obs(sel), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        int sel, gap;
        RESET = 1'b1;
        if0.AES_START = 1'b0;
        if1.AES_START = 1'b0;
        repeat (2) step();
        chk_obs("cfg0 in_reset", get_obs(0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk_obs("cfg1 in_reset", get_obs(1), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        RESET = 1'b0;
        step();
        chk_obs("cfg0 idle", get_obs(0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // default parameters, start held high, done held 3 extra cycles
        do_run(0, 10, 1, 3, 1'b0, -1);
        // one-cycle start pulse: done rises then falls on the next edge
        do_run(0, 10, 1, 0, 1'b0, -1);
        // start glitching mid-run, then immediate restart from the IDLE cycle after DONE
        do_run(0, 10, 1, 2, 1'b1, -1);
        do_run(0, 10, 1, 1, 1'b0, -1);
        // SBOX_LAT=3, KEYEXP_CYCLES=4
        do_run(1, 4, 3, 1, 1'b0, -1);
        do_run(1, 4, 3, 0, 1'b1, -1);
        // reset in the last InvMixColumns cycle of round 4, then a fresh run
        do_run(0, 10, 1, 0, 1'b0, 10 + 2 + 3 * 7 + 3 + 3);
        do_run(0, 10, 1, 1, 1'b0, -1);

        // randomised runs with random gaps
        repeat (6) begin
            sel = int'($urandom_range(0, 1));
            if (sel == 1) do_run(1, 4, 3, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
            else          do_run(0, 10, 1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                step();
                chk_obs($sformatf("gap_idle sel%0d", sel), get_obs(sel), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
